// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet framer and deframer:
// frame marker default, framing state encoding and checksum finalize.
package uart_pkt_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    SOF     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4
  } pkt_state_e;

  // Checksum byte that makes LEN + payload + CSUM wrap to zero.
  function automatic logic [7:0] csum_finalize(input logic [7:0] len,
                                               input logic [7:0] sum);
    return 8'h00 - len - sum;
  endfunction

endpackage

// File: rtl/uart_pkt_csum.sv
// Running 8-bit payload sum with clear, plus the finalized checksum byte.
module uart_pkt_csum
  import uart_pkt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  input  logic [7:0] len_i,
  output logic [7:0] sum_o,
  output logic [7:0] csum_o
);

  logic [7:0] sum_q, sum_d;

  // Clear has priority; otherwise add the accepted byte modulo 256.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Sum register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o  = sum_q;
  assign csum_o = csum_finalize(len_i, sum_q);

endmodule

// File: rtl/uart_packet_framer.sv
// Collects one packet of upstream bytes, then pushes SOF, LEN, payload
// and CSUM into the clock-crossing FIFO, stalling on the FIFO full flag.
//
// Handshakes: upstream byte transfers when s_valid && s_ready in the same
// cycle; the FIFO takes a byte in every cycle fifo_wr_en is high, and
// fifo_wr_en is only raised when fifo_full is low, so a stalled byte stays
// on fifo_wr_data until it is pushed.
module uart_packet_framer
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 16,
  parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT
)(
  input  logic       wr_clk,
  input  logic       wr_rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wr_data,
  output logic       busy,
  output logic       pkt_sent,
  output pkt_state_e dbg_state_o
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  pkt_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [7:0]      len_q, len_d;
  logic            pkt_sent_q, pkt_sent_d;
  logic [7:0]      buf_q [MAX_PAYLOAD];

  logic            accept;
  logic            push;
  logic            csum_clr;
  logic [CW-1:0]   cnt_inc;
  logic [7:0]      sum;
  logic [7:0]      csum;

  assign s_ready     = (state_q == COLLECT);
  assign busy        = !s_ready;
  assign accept      = s_valid && s_ready;
  assign fifo_wr_en  = busy && !fifo_full;
  assign push        = fifo_wr_en;
  assign cnt_inc     = cnt_q + CW'(1);
  assign csum_clr    = (state_q == CSUM) && push;
  assign pkt_sent    = pkt_sent_q;
  assign dbg_state_o = state_q;

  uart_pkt_csum u_csum (
    .clk_i  (wr_clk),
    .rst_i  (wr_rst),
    .clr_i  (csum_clr),
    .add_i  (accept),
    .data_i (s_data),
    .len_i  (len_q),
    .sum_o  (sum),
    .csum_o (csum)
  );

  // Byte presented to the FIFO; held stable while the state is stalled.
  always_comb begin
    fifo_wr_data = 8'h00;
    case (state_q)
      SOF:     fifo_wr_data = SOF_BYTE;
      LEN:     fifo_wr_data = len_q;
      PAYLOAD: fifo_wr_data = buf_q[idx_q[AW-1:0]];
      CSUM:    fifo_wr_data = csum;
      default: fifo_wr_data = 8'h00;
    endcase
  end

  // Next-state: collect until close, then walk the frame one push at a time.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    pkt_sent_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (s_last || (cnt_inc == CW'(MAX_PAYLOAD))) begin
            len_d   = 8'(cnt_inc);
            state_d = SOF;
          end
        end
      end
      SOF: begin
        if (push) state_d = LEN;
      end
      LEN: begin
        if (push) begin
          idx_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (push) begin
          if ((8'(idx_q) + 8'd1) == len_q) begin
            state_d = CSUM;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      CSUM: begin
        if (push) begin
          cnt_d      = '0;
          pkt_sent_d = 1'b1;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Control registers; reset discards any partial packet.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      idx_q      <= '0;
      len_q      <= 8'h00;
      pkt_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      pkt_sent_q <= pkt_sent_d;
    end
  end

  // Payload storage; contents are only read after being written this packet.
  always_ff @(posedge wr_clk) begin
    if (accept) begin
      buf_q[cnt_q[AW-1:0]] <= s_data;
    end
  end

endmodule
